vending_mcn_param: RTL and testbench

Parametrised successor to the fixed 4-state coin FSM. It accepts coins of three configurable denominations and accumulates credit up to a configurable price. It then issues a vend request with a valid/ready handshake and returns change greedily through a second handshake. Cancel refunds the full credit. The block sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_pkg.sv | 26 ++
 rtl/vend_change_gen.sv | 62 ++++++
 rtl/vending_mcn_param.sv | 145 ++++++++++++++
 tb/tb_vending_mcn_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller.
//   state_t       : 2-bit FSM encoding (IDLE=0, CREDIT=1, VEND=2, CHANGE=3)
//   DEF_COIN_*    : default coin denominations
//   is_legal_coin : denomination membership test
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam int unsigned DEF_COIN_A = 5;
  localparam int unsigned DEF_COIN_B = 10;
  localparam int unsigned DEF_COIN_C = 25;

  // True when val is one of the three accepted denominations.
  function automatic logic is_legal_coin(input int unsigned val,
                                         input int unsigned coin_a,
                                         input int unsigned coin_b,
                                         input int unsigned coin_c);
    return (val == coin_a) || (val == coin_b) || (val == coin_c);
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change dispenser: holds the remaining change, picks coins greedily and
// runs the chg_valid/chg_ready handshake towards the hopper.
//   load/amount : capture a new change amount (amount 0 issues nothing)
//   chg_valid   : change coin available (registered)
//   chg_coin    : COIN_B while remaining >= COIN_B, else COIN_A (registered)
//   chg_ready   : hopper accepts the coin
//   done_c      : the coin accepted this cycle is the last one
module vend_change_gen
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned COIN_A   = DEF_COIN_A,
  parameter int unsigned COIN_B   = DEF_COIN_B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] amount,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_coin,
  input  logic                chg_ready,
  output logic                done_c
);

  localparam logic [CREDIT_W-1:0] COIN_A_V = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] COIN_B_V = CREDIT_W'(COIN_B);

  logic [CREDIT_W-1:0] rem_r;
  logic [CREDIT_W-1:0] rem_after_c;
  logic                xfer_c;

  // Greedy pick; remaining change is always a multiple of COIN_A.
  function automatic logic [CREDIT_W-1:0] pick(input logic [CREDIT_W-1:0] v);
    return (v >= COIN_B_V) ? COIN_B_V : COIN_A_V;
  endfunction

  assign xfer_c      = chg_valid && chg_ready;
  assign rem_after_c = rem_r - chg_coin;
  assign done_c      = xfer_c && (rem_after_c == '0);

  // Remaining-change register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r     <= '0;
      chg_valid <= 1'b0;
      chg_coin  <= '0;
    end else if (load) begin
      rem_r     <= amount;
      chg_valid <= (amount != '0);
      chg_coin  <= (amount != '0) ? pick(amount) : '0;
    end else if (xfer_c) begin
      rem_r <= rem_after_c;
      if (rem_after_c == '0) begin
        chg_valid <= 1'b0;
        chg_coin  <= '0;
      end else begin
        chg_coin <= pick(rem_after_c);
      end
    end
  end

endmodule

// File: rtl/vending_mcn_param.sv
// Parametrised coin-credit vending controller.
//   coin_valid/coin_val : coin strobe from the acceptor
//   cancel              : refund request (honoured in CREDIT only)
//   vend_valid/ready    : dispense handshake
//   chg_valid/coin/ready: change handshake (via vend_change_gen)
//   coin_reject         : one-cycle pulse after a refused coin
//   credit, state       : register outputs
module vending_mcn_param
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned COIN_A     = DEF_COIN_A,
  parameter int unsigned COIN_B     = DEF_COIN_B,
  parameter int unsigned COIN_C     = DEF_COIN_C,
  parameter int unsigned PRICE      = 15,
  parameter int unsigned MAX_CREDIT = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_val,
  input  logic                cancel,
  output logic                vend_valid,
  input  logic                vend_ready,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_coin,
  input  logic                chg_ready,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  // Parameter sanity; any violation aborts elaboration.
  if (COIN_A == 0 || COIN_B != 2 * COIN_A || (COIN_C % COIN_A) != 0 ||
      PRICE == 0 || (PRICE % COIN_A) != 0 || PRICE > MAX_CREDIT ||
      (MAX_CREDIT >> CREDIT_W) != 0) begin : g_param_err
    $fatal(1, "vending_mcn_param: illegal parameter combination");
  end

  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_V   = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state_r, state_n;
  logic [CREDIT_W-1:0] credit_r, credit_n;
  logic                vend_valid_r, vend_valid_n;
  logic                reject_r, reject_n;
  logic                load_c;
  logic [CREDIT_W-1:0] amount_c;
  logic                done_c;
  logic [CREDIT_W:0]   sum_c;
  logic                coin_ok_c;
  logic [CREDIT_W-1:0] vend_rem_c;

  // Sum kept one bit wider so an overflowing coin cannot wrap into range.
  assign sum_c      = {1'b0, credit_r} + {1'b0, coin_val};
  assign coin_ok_c  = is_legal_coin(32'(coin_val), COIN_A, COIN_B, COIN_C) &&
                      (sum_c <= MAX_V);
  assign vend_rem_c = credit_r - PRICE_V;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      credit_r     <= '0;
      vend_valid_r <= 1'b0;
      reject_r     <= 1'b0;
    end else begin
      state_r      <= state_n;
      credit_r     <= credit_n;
      vend_valid_r <= vend_valid_n;
      reject_r     <= reject_n;
    end
  end

  // Next-state, credit and change-load decode.
  always_comb begin
    state_n  = state_r;
    credit_n = credit_r;
    reject_n = 1'b0;
    load_c   = 1'b0;
    amount_c = credit_r;
    unique case (state_r)
      ST_IDLE, ST_CREDIT: begin
        if (state_r == ST_CREDIT && cancel) begin
          // Cancel beats a simultaneous coin; the coin is refused.
          state_n  = ST_CHANGE;
          load_c   = 1'b1;
          reject_n = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok_c) begin
            credit_n = sum_c[CREDIT_W-1:0];
            state_n  = (sum_c[CREDIT_W-1:0] >= PRICE_V) ? ST_VEND : ST_CREDIT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      ST_VEND: begin
        reject_n = coin_valid;
        if (vend_ready) begin
          credit_n = vend_rem_c;
          amount_c = vend_rem_c;
          if (vend_rem_c != '0) begin
            state_n = ST_CHANGE;
            load_c  = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        reject_n = coin_valid;
        if (chg_valid && chg_ready) begin
          credit_n = credit_r - chg_coin;
        end
        if (done_c) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    vend_valid_n = (state_n == ST_VEND);
  end

  vend_change_gen #(
    .CREDIT_W (CREDIT_W),
    .COIN_A   (COIN_A),
    .COIN_B   (COIN_B)
  ) u_change (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .amount    (amount_c),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .chg_ready (chg_ready),
    .done_c    (done_c)
  );

  assign vend_valid  = vend_valid_r;
  assign coin_reject = reject_r;
  assign credit      = credit_r;
  assign state       = state_r;

endmodule

// File: tb/tb_vending_mcn_param.sv
// Scoreboard bench for vending_mcn_param with default parameters
// (coins 5/10/25, price 15, max credit 30).
module tb_vending_mcn_param;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         coin_valid;
  logic [W-1:0] coin_val;
  logic         cancel;
  logic         vend_valid;
  logic         vend_ready;
  logic         chg_valid;
  logic [W-1:0] chg_coin;
  logic         chg_ready;
  logic         coin_reject;
  logic [W-1:0] credit;
  logic [1:0]   state;

  int checks   = 0;
  int failures = 0;

  // Expected events: credit at reject pulse, credit at vend handshake,
  // coin value at each change handshake.
  int rej_q[$];
  int vend_q[$];
  int chg_q[$];
  int mon_e;

  always #5 clk = ~clk;

  vending_mcn_param dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .cancel      (cancel),
    .vend_valid  (vend_valid),
    .vend_ready  (vend_ready),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .chg_ready   (chg_ready),
    .coin_reject (coin_reject),
    .credit      (credit),
    .state       (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (coin_reject) begin
        if (rej_q.size() == 0) chk("unexpected_reject", 1, 0);
        else begin
          mon_e = rej_q.pop_front();
          chk("reject_credit", int'(credit), mon_e);
        end
      end
      if (vend_valid && vend_ready) begin
        if (vend_q.size() == 0) chk("unexpected_vend", 1, 0);
        else begin
          mon_e = vend_q.pop_front();
          chk("vend_credit", int'(credit), mon_e);
        end
      end
      if (chg_valid && chg_ready) begin
        if (chg_q.size() == 0) chk("unexpected_chg", 1, 0);
        else begin
          mon_e = chg_q.pop_front();
          chk("chg_coin", int'(chg_coin), mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_val   = W'(v);
    tick();
    coin_valid = 1'b0;
    coin_val   = '0;
  endtask

  task automatic vend_hs();
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
  endtask

  task automatic chg_hs();
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
  endtask

  task automatic expect_sc(input string name, input int st, input int cr);
    chk({name, "_state"}, int'(state), st);
    chk({name, "_credit"}, int'(credit), cr);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (state != 2'd0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle", int'(state), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    vend_ready = 1'b0; chg_ready = 1'b0;
    tick();
    tick();
    expect_sc("reset", 0, 0);
    chk("reset_vend_valid", int'(vend_valid), 0);
    chk("reset_chg_valid", int'(chg_valid), 0);
    chk("reset_chg_coin", int'(chg_coin), 0);
    chk("reset_reject", int'(coin_reject), 0);
    rst = 1'b0;
    tick();

    // 1: exact price, no change
    coin(5);   expect_sc("t1_c5", 1, 5);
    coin(10);  expect_sc("t1_c10", 2, 15);
    chk("t1_vend_valid", int'(vend_valid), 1);
    vend_q.push_back(15);
    vend_hs(); expect_sc("t1_vended", 0, 0);
    chk("t1_chg_valid", int'(chg_valid), 0);
    chk("t1_vend_drop", int'(vend_valid), 0);

    // 2: overpay by 10, one change coin
    coin(25);  expect_sc("t2_c25", 2, 25);
    vend_q.push_back(25);
    vend_hs(); expect_sc("t2_vended", 3, 10);
    chk("t2_chg_valid", int'(chg_valid), 1);
    chk("t2_chg_coin", int'(chg_coin), 10);
    chg_q.push_back(10);
    chg_hs();  expect_sc("t2_done", 0, 0);
    chk("t2_chg_clear", int'(chg_valid), 0);
    chk("t2_chg_coin_clear", int'(chg_coin), 0);

    // 3: cancel refund
    coin(10);  expect_sc("t3_c10", 1, 10);
    cancel = 1'b1; tick(); cancel = 1'b0;
    expect_sc("t3_cancel", 3, 10);
    chk("t3_chg_coin", int'(chg_coin), 10);
    chk("t3_no_vend", int'(vend_valid), 0);
    chg_q.push_back(10);
    chg_hs();  expect_sc("t3_done", 0, 0);

    // cancel in IDLE is ignored
    cancel = 1'b1; tick(); cancel = 1'b0;
    expect_sc("idle_cancel", 0, 0);

    // 4: illegal value, overflow, coin during VEND
    rej_q.push_back(0);
    coin(7);   expect_sc("t4_c7", 0, 0);
    chk("t4_reject_pulse", int'(coin_reject), 1);
    tick();
    chk("t4_reject_end", int'(coin_reject), 0);
    coin(10);  expect_sc("t4_c10", 1, 10);
    rej_q.push_back(10);
    coin(25);  expect_sc("t4_over", 1, 10);
    chk("t4_over_reject", int'(coin_reject), 1);
    coin(5);   expect_sc("t4_c5", 2, 15);
    rej_q.push_back(15);
    coin(10);  expect_sc("t4_vend_coin", 2, 15);
    chk("t4_vend_reject", int'(coin_reject), 1);
    vend_q.push_back(15);
    vend_hs(); expect_sc("t4_vended", 0, 0);

    // 5: coin and cancel together in CREDIT
    coin(5);   expect_sc("t5_c5", 1, 5);
    rej_q.push_back(5);
    coin_valid = 1'b1; coin_val = W'(10); cancel = 1'b1;
    tick();
    coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    expect_sc("t5_cancel", 3, 5);
    chk("t5_chg_coin", int'(chg_coin), 5);
    chk("t5_reject", int'(coin_reject), 1);
    chg_q.push_back(5);
    chg_hs();  expect_sc("t5_done", 0, 0);

    // boundary: credit exactly MAX_CREDIT, change 15 = 10 + 5
    coin(5);   expect_sc("max_c5", 1, 5);
    coin(25);  expect_sc("max_c25", 2, 30);
    vend_q.push_back(30);
    vend_hs(); expect_sc("max_vended", 3, 15);
    chg_q.push_back(10);
    chg_q.push_back(5);
    chg_ready = 1'b1;
    wait_idle(10);
    chg_ready = 1'b0;
    chk("max_credit_end", int'(credit), 0);

    // 6: hopper stall, then reset mid-CHANGE
    coin(25);
    vend_q.push_back(25);
    vend_hs(); expect_sc("t6_vended", 3, 10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_stall_valid", int'(chg_valid), 1);
      chk("t6_stall_coin", int'(chg_coin), 10);
    end
    rst = 1'b1;
    #1;
    expect_sc("t6_rst", 0, 0);
    chk("t6_rst_chg_valid", int'(chg_valid), 0);
    chk("t6_rst_chg_coin", int'(chg_coin), 0);
    chk("t6_rst_vend_valid", int'(vend_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    expect_sc("t6_after", 0, 0);

    chk("rej_q_empty", rej_q.size(), 0);
    chk("vend_q_empty", vend_q.size(), 0);
    chk("chg_q_empty", chg_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
